// File: rtl/conversor_bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package conversor_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } estado_t;

  localparam int          N_SHIFT       = 17;
  localparam int          N_DIGITOS     = 5;
  localparam int          W_BCD         = 4 * N_DIGITOS;
  localparam int          W_CNT         = 5;
  localparam logic [3:0]  DIGITO_ERRO   = 4'hF;
  localparam int unsigned LIMITE_PADRAO = 99999;

endpackage

// File: rtl/conversor_bcd_corretor.sv
// One double-dabble correction cell: a BCD nibble of 5 or more gets +3
// so that the following left shift carries correctly into the next digit.
module corretor_bcd (
  input  logic [3:0] d,
  output logic [3:0] q
);

  // Add-3 correction, purely combinational.
  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/conversor_bcd.sv
// Sequential binary-to-BCD converter (shift-add-3). Values above LIMITE
// produce all-F digits with overflow set; digits only change when done rises.
module conversor_bcd
  import conversor_bcd_pkg::*;
#(
  parameter int          W_ENTRADA = 32,
  parameter int unsigned LIMITE    = LIMITE_PADRAO
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [W_ENTRADA-1:0] entrada,
  output logic [3:0]           bcd0,
  output logic [3:0]           bcd1,
  output logic [3:0]           bcd2,
  output logic [3:0]           bcd3,
  output logic [3:0]           bcd4,
  output logic                 overflow,
  output logic                 busy,
  output logic                 done
);

  localparam logic [W_ENTRADA-1:0] LIMITE_W = W_ENTRADA'(LIMITE);

  estado_t            estado, estado_prox;
  logic [N_SHIFT-1:0] binario;
  logic [W_BCD-1:0]   acum;
  logic [W_BCD-1:0]   acum_corr;
  logic [W_BCD-1:0]   acum_prox;
  logic [W_BCD-1:0]   saida;
  logic [W_CNT-1:0]   cnt;
  logic               acima_limite;
  logic               ultimo_shift;

  assign acima_limite = (entrada > LIMITE_W);
  assign ultimo_shift = (cnt == W_CNT'(N_SHIFT - 1));

  // One correction cell per accumulator digit.
  for (genvar gi = 0; gi < N_DIGITOS; gi++) begin : g_corretor
    corretor_bcd u_corretor (
      .d (acum[4*gi +: 4]),
      .q (acum_corr[4*gi +: 4])
    );
  end

  // Accumulator value after the current cycle's correct-then-shift step.
  assign acum_prox = {acum_corr[W_BCD-2:0], binario[N_SHIFT-1]};

  // Next-state decode.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    estado_prox = estado;
    case (estado)
      IDLE:    if (start) estado_prox = acima_limite ? DONE : SHIFT;
      SHIFT:   if (ultimo_shift) estado_prox = DONE;
      DONE:    estado_prox = IDLE;
      default: estado_prox = IDLE;
    endcase
  end

  // State register; busy and done are flopped from the next state so they are glitch-free.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      estado <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      estado <= estado_prox;
      busy   <= (estado_prox != IDLE);
      done   <= (estado_prox == DONE);
    end
  end

  // Capture, shift-add-3 datapath and result registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      binario  <= '0;
      acum     <= '0;
      cnt      <= '0;
      saida    <= '0;
      overflow <= 1'b0;
    end else begin
      case (estado)
        IDLE: begin
          if (start) begin
            acum <= '0;
            cnt  <= '0;
            if (acima_limite) begin
              saida    <= {N_DIGITOS{DIGITO_ERRO}};
              overflow <= 1'b1;
            end else begin
              binario <= entrada[N_SHIFT-1:0];
            end
          end
        end
        SHIFT: begin
          acum    <= acum_prox;
          binario <= {binario[N_SHIFT-2:0], 1'b0};
          cnt     <= cnt + 1'b1;
          if (ultimo_shift) begin
            saida    <= acum_prox;
            overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bcd0 = saida[3:0];
  assign bcd1 = saida[7:4];
  assign bcd2 = saida[11:8];
  assign bcd3 = saida[15:12];
  assign bcd4 = saida[19:16];

endmodule

// File: tb/tb_conversor_bcd.sv
// Self-checking bench for conversor_bcd: directed cases plus random values
// compared against a decimal-arithmetic reference model.
module tb_conversor_bcd;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] entrada;
  logic [3:0]  bcd0, bcd1, bcd2, bcd3, bcd4;
  logic        overflow, busy, done;

  int passed = 0;
  int total  = 0;
  logic [19:0] prev_exp;

  conversor_bcd dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .entrada  (entrada),
    .bcd0     (bcd0),
    .bcd1     (bcd1),
    .bcd2     (bcd2),
    .bcd3     (bcd3),
    .bcd4     (bcd4),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end, expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [19:0] digitos(input logic [31:0] v);
    logic [19:0] r;
    longint unsigned x;
    r = '0;
    if (v > 32'd99999) return 20'hFFFFF;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [19:0] obs_digitos();
    return {bcd4, bcd3, bcd2, bcd1, bcd0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Full conversion with latency, hold, result and post-done checks.
  task automatic do_conv(input logic [31:0] v);
    int lat;
    int exp_lat;
    exp_lat = (v > 32'd99999) ? 1 : 18;
    entrada = v;
    start   = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("busy_after_accept", busy, 1);
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      if (lat == 10) check("digits_held", obs_digitos(), prev_exp);
      @(posedge clock); #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    check("digits", obs_digitos(), digitos(v));
    check("overflow", overflow, (v > 32'd99999) ? 1 : 0);
    prev_exp = digitos(v);
    @(posedge clock); #1;
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    int n_done;
    int tempos[$];
    logic [31:0] v;

    reset = 1'b1; start = 1'b0; entrada = '0;
    prev_exp = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("reset_digits", obs_digitos(), 0);
    check("reset_overflow", overflow, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);

    // Zero, then typical and boundary values.
    do_conv(32'd0);
    do_conv(32'd12345);
    do_conv(32'd99999);
    do_conv(32'd100000);
    do_conv(32'hFFFFFFFF);
    do_conv(32'd7);
    do_conv(32'd100000);
    do_conv(32'd99999);

    // start pulses during SHIFT and DONE must be ignored.
    entrada = 32'd42;
    start   = 1'b1;
    @(posedge clock); #1;
    start  = 1'b0;
    n_done = 0;
    for (int c = 1; c <= 25; c++) begin
      if (c == 3 || c == 17 || c == 18) begin
        start = 1'b1; entrada = 32'd555;
      end
      @(posedge clock); #1;
      start = 1'b0;
      if (done === 1'b1) n_done++;
    end
    check("ignored_start_done_count", n_done, 1);
    check("ignored_start_digits", obs_digitos(), digitos(32'd42));
    check("ignored_start_idle", busy, 0);
    prev_exp = digitos(32'd42);

    // Reset in the middle of a conversion.
    entrada = 32'd54321;
    start   = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("midreset_digits", obs_digitos(), 0);
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    n_done = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clock); #1;
      if (done === 1'b1) n_done++;
    end
    check("midreset_no_done", n_done, 0);
    prev_exp = '0;
    do_conv(32'd10);

    // start held high: one conversion every 19 cycles.
    entrada = 32'd31415;
    start   = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      @(posedge clock); #1;
      if (done === 1'b1) tempos.push_back(c);
    end
    start = 1'b0;
    repeat (30) @(posedge clock);
    #1;
    check("b2b_done_count", tempos.size(), 3);
    for (int i = 1; i < tempos.size(); i++)
      check("b2b_spacing", tempos[i] - tempos[i-1], 19);
    check("b2b_digits", obs_digitos(), digitos(32'd31415));
    prev_exp = digitos(32'd31415);

    // Random values, mostly in range with some overflowing.
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) == 0) v = $urandom;
      else v = $urandom_range(0, 99999);
      do_conv(v);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
